// File: rtl/ram_port_ctrl.sv
// Host-side controller for a single-port RAM: valid/ready request port, registered RAM drive,
// registered read response. An optional post-reset sweep writes INIT_VALUE to every location.
module ram_port_ctrl #(
    parameter int                    ADDR_WIDTH     = 4,
    parameter int                    DATA_WIDTH     = 8,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RESP
    } state_t;

    localparam state_t                RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state, state_nx;
    logic                  req_ready_nx;
    logic                  rsp_valid_nx;
    logic [DATA_WIDTH-1:0] rsp_rdata_nx;
    logic                  init_done_nx;
    logic                  mem_we_nx;
    logic [ADDR_WIDTH-1:0] mem_addr_nx;
    logic [DATA_WIDTH-1:0] mem_din_nx;

    always_comb begin
        state_nx     = state;
        req_ready_nx = req_ready;
        rsp_valid_nx = rsp_valid;
        rsp_rdata_nx = rsp_rdata;
        init_done_nx = init_done;
        mem_we_nx    = mem_we;
        mem_addr_nx  = mem_addr;
        mem_din_nx   = mem_din;

        case (state)
            S_CLEAR: begin
                // mem_we low in CLEAR means the sweep has not started yet
                if (!mem_we) begin
                    mem_we_nx   = 1'b1;
                    mem_addr_nx = '0;
                    mem_din_nx  = INIT_VALUE;
                end else if (mem_addr == LAST_ADDR) begin
                    mem_we_nx    = 1'b0;
                    init_done_nx = 1'b1;
                    req_ready_nx = 1'b1;
                    state_nx     = S_IDLE;
                end else begin
                    mem_addr_nx = mem_addr + ADDR_ONE;
                end
            end

            S_IDLE: begin
                mem_we_nx = 1'b0;
                // Only reachable with req_ready low straight out of reset when the sweep is disabled
                if (!req_ready) begin
                    req_ready_nx = 1'b1;
                    init_done_nx = 1'b1;
                end else if (req_valid) begin
                    req_ready_nx = 1'b0;
                    mem_addr_nx  = req_addr;
                    if (req_we) begin
                        mem_we_nx  = 1'b1;
                        mem_din_nx = req_wdata;
                        state_nx   = S_WRITE;
                    end else begin
                        state_nx   = S_READ;
                    end
                end
            end

            S_WRITE: begin
                mem_we_nx    = 1'b0;
                req_ready_nx = 1'b1;
                state_nx     = S_IDLE;
            end

            S_READ: begin
                rsp_rdata_nx = mem_dout;
                rsp_valid_nx = 1'b1;
                state_nx     = S_RESP;
            end

            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nx = 1'b0;
                    req_ready_nx = 1'b1;
                    state_nx     = S_IDLE;
                end
            end

            default: begin
                state_nx = RST_STATE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST_STATE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            init_done <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
        end else begin
            state     <= state_nx;
            req_ready <= req_ready_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_rdata <= rsp_rdata_nx;
            init_done <= init_done_nx;
            mem_we    <= mem_we_nx;
            mem_addr  <= mem_addr_nx;
            mem_din   <= mem_din_nx;
        end
    end

endmodule
